// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO with flush; push and pop may occur in the same cycle.
module fetch_buffer #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [1:0]       o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues ready/valid word fetches, buffers returns and drives IF/ID.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        stallDecode,
  output logic        ifidValid,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPc,
  output logic [31:0] ifidPcPlus4
);

  logic        r_run;
  logic [31:0] r_fetch_pc;
  logic [1:0]  r_in_flight;
  logic [1:0]  r_drop_count;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;

  logic [31:0]  w_fetch_pc_d;
  logic [1:0]   w_in_flight_d;
  logic [1:0]   w_drop_count_d;
  logic         w_ifid_valid_d;
  logic [31:0]  w_ifid_instr_d;
  logic [31:0]  w_ifid_pc_d;
  logic [2:0]   w_occupancy;
  logic         w_issue;
  logic         w_rsp_ret;
  logic         w_rsp_live;
  logic         w_bypass;
  logic         w_buf_push;
  logic         w_buf_pop;
  logic [1:0]   w_buf_count;
  logic [1:0]   w_pcq_count;
  logic [31:0]  w_pcq_head;
  fetch_entry_t w_buf_head;
  fetch_entry_t w_rsp_entry;

  assign w_occupancy = {1'b0, r_in_flight} + {1'b0, w_buf_count};
  assign imemReq     = r_run && !redirectValid && (32'(w_occupancy) < FETCH_DEPTH);
  assign imemAddr    = {r_fetch_pc[31:2], 2'b00};
  assign w_issue     = imemReq && imemReady;
  assign w_rsp_ret   = imemRspValid && (r_in_flight != 2'd0);
  assign w_rsp_live  = imemRspValid && (r_drop_count == 2'd0) && !redirectValid;
  assign w_bypass    = w_rsp_live && (w_buf_count == 2'd0) && !stallDecode;
  assign w_buf_push  = w_rsp_live && !w_bypass;
  assign w_buf_pop   = !redirectValid && !stallDecode && (w_buf_count != 2'd0);
  assign w_rsp_entry = '{pc: w_pcq_head, instr: imemRspData};

  fetch_buffer #(
    .WIDTH($bits(fetch_entry_t))
  ) u_instr_buf (
    .clock  (clock),
    .resetN (resetN),
    .i_push (w_buf_push),
    .i_data (w_rsp_entry),
    .i_pop  (w_buf_pop),
    .i_flush(redirectValid),
    .o_count(w_buf_count),
    .o_head (w_buf_head)
  );

  // Outstanding PCs pair each in-order response with its address; dropped ones still pop.
  fetch_buffer #(
    .WIDTH(32)
  ) u_pc_queue (
    .clock  (clock),
    .resetN (resetN),
    .i_push (w_issue),
    .i_data (r_fetch_pc),
    .i_pop  (imemRspValid && (w_pcq_count != 2'd0)),
    .i_flush(1'b0),
    .o_count(w_pcq_count),
    .o_head (w_pcq_head)
  );

  always_comb begin
    w_fetch_pc_d   = r_fetch_pc;
    w_in_flight_d  = r_in_flight + {1'b0, w_issue} - {1'b0, w_rsp_ret};
    w_drop_count_d = r_drop_count;
    w_ifid_valid_d = r_ifid_valid;
    w_ifid_instr_d = r_ifid_instr;
    w_ifid_pc_d    = r_ifid_pc;

    if (redirectValid) begin
      w_fetch_pc_d   = redirectTarget & 32'hFFFF_FFFC;
      w_drop_count_d = r_in_flight - {1'b0, w_rsp_ret};
      w_ifid_valid_d = 1'b0;
      w_ifid_instr_d = NOP_INSTR;
    end else begin
      if (w_issue) begin
        w_fetch_pc_d = r_fetch_pc + 32'd4;
      end
      if (imemRspValid && (r_drop_count != 2'd0)) begin
        w_drop_count_d = r_drop_count - 2'd1;
      end
      if (!stallDecode) begin
        if (w_buf_count != 2'd0) begin
          w_ifid_valid_d = 1'b1;
          w_ifid_instr_d = w_buf_head.instr;
          w_ifid_pc_d    = w_buf_head.pc;
        end else if (w_bypass) begin
          w_ifid_valid_d = 1'b1;
          w_ifid_instr_d = imemRspData;
          w_ifid_pc_d    = w_pcq_head;
        end else begin
          w_ifid_valid_d = 1'b0;
          w_ifid_instr_d = NOP_INSTR;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_run        <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_in_flight  <= 2'd0;
      r_drop_count <= 2'd0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= 32'd0;
    end else begin
      r_run        <= 1'b1;
      r_fetch_pc   <= w_fetch_pc_d;
      r_in_flight  <= w_in_flight_d;
      r_drop_count <= w_drop_count_d;
      r_ifid_valid <= w_ifid_valid_d;
      r_ifid_instr <= w_ifid_instr_d;
      r_ifid_pc    <= w_ifid_pc_d;
    end
  end

  assign ifidValid       = r_ifid_valid;
  assign ifidInstruction = r_ifid_instr;
  assign ifidPc          = r_ifid_pc;
  assign ifidPcPlus4     = r_ifid_pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench: in-order variable-latency memory plus a program-order stream model of IF/ID.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b0;
  logic        imemRspValid = 1'b0;
  logic [31:0] imemRspData = '0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        stallDecode = 1'b0;
  logic        ifidValid;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPc;
  logic [31:0] ifidPcPlus4;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FETCH_DEPTH(2)
  ) dut (
    .clock          (clock),
    .resetN         (resetN),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemReady      (imemReady),
    .imemRspValid   (imemRspValid),
    .imemRspData    (imemRspData),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .stallDecode    (stallDecode),
    .ifidValid      (ifidValid),
    .ifidInstruction(ifidInstruction),
    .ifidPc         (ifidPc),
    .ifidPcPlus4    (ifidPcPlus4)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5B;
  endfunction

  // Memory model: accepted addresses with the cycle their response is due.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          last_due;
  int          cyc;
  int          lat_min, lat_max;

  // Stream model and previous-cycle observations.
  logic [31:0] exp_pc;
  logic        await_first;
  int          since_redir;
  int          valid_count;
  logic        prev_redir, prev_stall, prev_req, prev_ready;
  logic [31:0] prev_target, prev_addr;
  logic        prev_valid;
  logic [31:0] prev_instr, prev_pc;
  logic        cur_req;
  logic [31:0] cur_addr;

  task automatic step(input logic stall, input logic redir, input logic [31:0] target,
                      input logic ready);
    int due;
    @(negedge clock);
    stallDecode    = stall;
    redirectValid  = redir;
    redirectTarget = target;
    imemReady      = ready;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imemRspValid = 1'b1;
      imemRspData  = mem_word(q_addr[0]);
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = $urandom;
    end
    #1;
    cur_req  = imemReq;
    cur_addr = imemAddr;

    if (prev_redir) begin
      check_eq("redirect_bubble_valid", ifidValid, 1'b0);
      check_eq("redirect_bubble_nop", ifidInstruction, NOP_INSTR);
      if (imemReq) check_eq("redirect_target_addr", imemAddr, prev_target & 32'hFFFF_FFFC);
    end else if (prev_stall) begin
      check_eq("stall_hold_valid", ifidValid, prev_valid);
      check_eq("stall_hold_instr", ifidInstruction, prev_instr);
      check_eq("stall_hold_pc", ifidPc, prev_pc);
    end else if (ifidValid) begin
      check_eq("stream_pc", ifidPc, exp_pc);
      check_eq("stream_instr", ifidInstruction, mem_word(exp_pc));
      check_eq("stream_pc_plus4", ifidPcPlus4, exp_pc + 32'd4);
      if (await_first) begin
        check_eq("redirect_min_latency", since_redir >= 3, 1'b1);
        await_first = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      valid_count++;
    end else begin
      check_eq("bubble_nop", ifidInstruction, NOP_INSTR);
    end

    check_eq("outstanding_limit", q_addr.size() <= 2, 1'b1);
    if (prev_req && !prev_ready && !prev_redir && !redir) begin
      check_eq("addr_hold_req", imemReq, 1'b1);
      check_eq("addr_hold", imemAddr, prev_addr);
    end

    if (redir) begin
      check_eq("no_req_on_redirect", imemReq, 1'b0);
      exp_pc      = target & 32'hFFFF_FFFC;
      await_first = 1'b1;
      since_redir = 0;
    end
    if (imemReq && imemReady) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q_addr.push_back(imemAddr);
      q_due.push_back(due);
    end
    if (imemRspValid) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end

    prev_redir  = redir;
    prev_stall  = stall;
    prev_req    = imemReq;
    prev_ready  = ready;
    prev_target = target;
    prev_addr   = imemAddr;
    prev_valid  = ifidValid;
    prev_instr  = ifidInstruction;
    prev_pc     = ifidPc;
    since_redir++;
    cyc++;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    imemReady = 1'b0;
    imemRspValid = 1'b0;
    redirectValid = 1'b0;
    stallDecode = 1'b0;
    q_addr.delete();
    q_due.delete();
    last_due = -1;
    cyc = 0;
    exp_pc = 32'h0;
    await_first = 1'b0;
    since_redir = 0;
    valid_count = 0;
    {prev_redir, prev_stall, prev_req, prev_ready, prev_valid} = '0;
    prev_target = '0;
    prev_addr = '0;
    prev_instr = NOP_INSTR;
    prev_pc = '0;
    repeat (2) @(negedge clock);
    #1;
    check_eq("reset_req", imemReq, 1'b0);
    check_eq("reset_addr", imemAddr, 32'h0);
    check_eq("reset_valid", ifidValid, 1'b0);
    check_eq("reset_instr", ifidInstruction, NOP_INSTR);
    check_eq("reset_pc", ifidPc, 32'h0);
    check_eq("reset_pc_plus4", ifidPcPlus4, 32'h4);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    lat_min = 1;
    lat_max = 1;
    do_reset();

    // Single-cycle memory streaming: first request at 0, then one instruction per cycle.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("first_req", cur_req, 1'b1);
    check_eq("first_addr", cur_addr, 32'h0);
    repeat (11) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("throughput", valid_count, 10);

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Two slow requests outstanding when the redirect lands.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && q_addr.size() < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("two_in_flight", q_addr.size(), 2);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    valid_count = 0;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redirect_progress", valid_count > 0, 1'b1);

    lat_min = 1;
    lat_max = 1;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    lat_min = 1;
    lat_max = 3;
    valid_count = 0;
    repeat (400) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
           $urandom_range(0, 9) < 7);
    end
    check_eq("random_progress", valid_count > 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
